// File: rtl/seq_decoder.sv
// Registered N-to-2^N one-hot decoder with valid/ready on both sides and an
// ascending/descending scan mode that walks a one-hot word across all outputs.
module seq_decoder #(
    parameter int N          = 3,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          sel,
    input  logic [1:0]            mode,
    output logic [(1 << N) - 1:0] d,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  last,
    output logic                  busy
);

    localparam int W  = 1 << N;
    localparam int CW = N + 1;
    localparam logic [CW-1:0] LastCount = CW'(W - 1);
    // XOR mask that applies the output polarity; also the all-idle word
    localparam logic [W-1:0] PolarityMask = {W{ACTIVE_LOW}};

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    typedef enum logic [1:0] {
        MODE_DECODE    = 2'b00,
        MODE_SCAN_UP   = 2'b01,
        MODE_SCAN_DOWN = 2'b10,
        MODE_CLEAR     = 2'b11
    } mode_t;

    state_t          state_q, state_d;
    mode_t           mode_q, mode_d;
    logic [N-1:0]    idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    d_q, d_d;
    logic            last_q, last_d;
    logic [N-1:0]    idxStep;
    logic [CW-1:0]   cntStep;
    mode_t           modeIn;

    function automatic logic [W-1:0] oneHot(input logic [N-1:0] index);
        logic [W-1:0] word;
        word        = '0;
        word[index] = 1'b1;
        return word;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_DECODE;
            idx_q   <= '0;
            cnt_q   <= '0;
            d_q     <= PolarityMask;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        last_d  = last_q;
        modeIn  = mode_t'(mode);
        idxStep = (mode_q == MODE_SCAN_DOWN) ? idx_q - N'(1) : idx_q + N'(1);
        cntStep = cnt_q + CW'(1);

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = EMIT;
                    mode_d  = modeIn;
                    idx_d   = sel;
                    cnt_d   = '0;
                    d_d     = (modeIn == MODE_CLEAR) ? PolarityMask : (oneHot(sel) ^ PolarityMask);
                    last_d  = (modeIn == MODE_DECODE) || (modeIn == MODE_CLEAR);
                end
            end
            EMIT: begin
                // Everything holds while the consumer stalls
                if (out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        last_d  = 1'b0;
                    end else begin
                        idx_d  = idxStep;
                        cnt_d  = cntStep;
                        d_d    = oneHot(idxStep) ^ PolarityMask;
                        last_d = (cntStep == LastCount);
                    end
                end
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == EMIT);
    assign busy      = (state_q == EMIT);
    assign d         = d_q;
    assign last      = last_q;

endmodule

// File: tb/tb_seq_decoder.sv
// Self-checking bench for seq_decoder: N=3 active-high instance driven through a
// scoreboard queue, plus an N=4 ACTIVE_LOW instance checked directly.
module tb_seq_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        aInValid = 1'b0;
    logic        aInReady;
    logic [2:0]  aSel = '0;
    logic [1:0]  aMode = '0;
    logic [7:0]  aD;
    logic        aOutValid;
    logic        aOutReady = 1'b1;
    logic        aLast;
    logic        aBusy;

    logic        bInValid = 1'b0;
    logic        bInReady;
    logic [3:0]  bSel = '0;
    logic [1:0]  bMode = '0;
    logic [15:0] bD;
    logic        bOutValid;
    logic        bOutReady = 1'b1;
    logic        bLast;
    logic        bBusy;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } beat_t;

    typedef struct {
        logic [2:0] sel;
        logic [1:0] mode;
        logic [7:0] expD;
        logic       expLast;
    } vector_t;

    beat_t   sbQueue[$];
    vector_t vectors[9];

    seq_decoder #(.N(3), .ACTIVE_LOW(1'b0)) dutA (
        .clk(clk), .rst(rst),
        .in_valid(aInValid), .in_ready(aInReady),
        .sel(aSel), .mode(aMode),
        .d(aD), .out_valid(aOutValid), .out_ready(aOutReady),
        .last(aLast), .busy(aBusy)
    );

    seq_decoder #(.N(4), .ACTIVE_LOW(1'b1)) dutB (
        .clk(clk), .rst(rst),
        .in_valid(bInValid), .in_ready(bInReady),
        .sel(bSel), .mode(bMode),
        .d(bD), .out_valid(bOutValid), .out_ready(bOutReady),
        .last(bLast), .busy(bBusy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL global timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        fails++;
        $display("[TB] FAIL %s: got timeout, expected completion", name);
    endtask

    // Reference model: every beat a request should produce, in order
    task automatic pushExpected(input logic [2:0] s, input logic [1:0] m);
        beat_t      b;
        logic [2:0] i;
        case (m)
            2'b00: begin
                b.d = 8'h01 << s; b.last = 1'b1; sbQueue.push_back(b);
            end
            2'b11: begin
                b.d = 8'h00; b.last = 1'b1; sbQueue.push_back(b);
            end
            default: begin
                for (int k = 0; k < 8; k++) begin
                    i      = (m == 2'b01) ? s + 3'(k) : s - 3'(k);
                    b.d    = 8'h01 << i;
                    b.last = (k == 7);
                    sbQueue.push_back(b);
                end
            end
        endcase
    endtask

    // Every valid cycle is compared against the queue head; a beat pops it
    task automatic sampleScoreboard();
        if (aOutValid) begin
            if (sbQueue.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected beat: got d=0x%0h, expected no beat", aD);
            end else begin
                checkOutput("beat d", 32'(aD), 32'(sbQueue[0].d));
                checkOutput("beat last", 32'(aLast), 32'(sbQueue[0].last));
                if (aOutReady) void'(sbQueue.pop_front());
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sampleScoreboard();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] s, input logic [1:0] m);
        int waitCount = 0;
        while (!aInReady && waitCount < 50) begin
            tick();
            waitCount++;
        end
        if (!aInReady) failNow("in_ready wait");
        aInValid = 1'b1;
        aSel     = s;
        aMode    = m;
        pushExpected(s, m);
        tick();
        aInValid = 1'b0;
    endtask

    task automatic drain(input bit toggleReady);
        int n = 0;
        while ((aOutValid || sbQueue.size() != 0) && n < 200) begin
            if (toggleReady) aOutReady = (n % 3 == 0);
            tick();
            n++;
        end
        if (n >= 200) failNow("drain");
        aOutReady = 1'b1;
    endtask

    initial begin
        vectors[0] = '{3'd0, 2'b00, 8'h01, 1'b1};
        vectors[1] = '{3'd1, 2'b00, 8'h02, 1'b1};
        vectors[2] = '{3'd2, 2'b00, 8'h04, 1'b1};
        vectors[3] = '{3'd3, 2'b00, 8'h08, 1'b1};
        vectors[4] = '{3'd4, 2'b00, 8'h10, 1'b1};
        vectors[5] = '{3'd5, 2'b00, 8'h20, 1'b1};
        vectors[6] = '{3'd6, 2'b00, 8'h40, 1'b1};
        vectors[7] = '{3'd7, 2'b00, 8'h80, 1'b1};
        vectors[8] = '{3'd5, 2'b11, 8'h00, 1'b1};

        @(posedge clk);
        #1;
        tick();
        rst = 1'b0;
        checkOutput("reset in_ready", 32'(aInReady), 32'd1);
        checkOutput("reset out_valid", 32'(aOutValid), 32'd0);
        checkOutput("reset busy", 32'(aBusy), 32'd0);
        checkOutput("reset last", 32'(aLast), 32'd0);
        checkOutput("reset d", 32'(aD), 32'h00);
        checkOutput("reset d active-low", 32'(bD), 32'hFFFF);
        checkOutput("reset in_ready active-low", 32'(bInReady), 32'd1);

        // Decode sweep and clear against the 3-to-8 truth table
        for (int v = 0; v < 9; v++) begin
            applyStimulus(vectors[v].sel, vectors[v].mode);
            checkOutput("vector d", 32'(aD), 32'(vectors[v].expD));
            checkOutput("vector last", 32'(aLast), 32'(vectors[v].expLast));
            checkOutput("vector out_valid", 32'(aOutValid), 32'd1);
            checkOutput("vector in_ready busy", 32'(aInReady), 32'd0);
            drain(1'b0);
            checkOutput("vector idle in_ready", 32'(aInReady), 32'd1);
            checkOutput("vector idle out_valid", 32'(aOutValid), 32'd0);
        end

        applyStimulus(3'd6, 2'b01);
        checkOutput("scan up first d", 32'(aD), 32'h40);
        drain(1'b0);
        checkOutput("scan up busy after", 32'(aBusy), 32'd0);

        applyStimulus(3'd1, 2'b10);
        checkOutput("scan down first d", 32'(aD), 32'h02);
        drain(1'b1);
        checkOutput("scan down busy after", 32'(aBusy), 32'd0);

        // Reset while the fourth beat of a scan is on the output
        applyStimulus(3'd0, 2'b01);
        tick();
        tick();
        tick();
        checkOutput("beat 4 d", 32'(aD), 32'h08);
        aOutReady = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sbQueue.delete();
        checkOutput("abort out_valid", 32'(aOutValid), 32'd0);
        checkOutput("abort busy", 32'(aBusy), 32'd0);
        checkOutput("abort d", 32'(aD), 32'h00);
        checkOutput("abort in_ready", 32'(aInReady), 32'd1);
        checkOutput("abort last", 32'(aLast), 32'd0);
        aOutReady = 1'b1;
        applyStimulus(3'd5, 2'b00);
        checkOutput("post-abort decode d", 32'(aD), 32'h20);
        drain(1'b0);

        // A request arriving during a stall must wait for IDLE
        aOutReady = 1'b0;
        applyStimulus(3'd2, 2'b00);
        aInValid = 1'b1;
        aSel     = 3'd3;
        aMode    = 2'b00;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("stall in_ready", 32'(aInReady), 32'd0);
            checkOutput("stall d", 32'(aD), 32'h04);
            checkOutput("stall out_valid", 32'(aOutValid), 32'd1);
        end
        aOutReady = 1'b1;
        tick();
        checkOutput("stall release in_ready", 32'(aInReady), 32'd1);
        checkOutput("stall release out_valid", 32'(aOutValid), 32'd0);
        pushExpected(3'd3, 2'b00);
        tick();
        aInValid = 1'b0;
        checkOutput("deferred request d", 32'(aD), 32'h08);
        checkOutput("deferred request out_valid", 32'(aOutValid), 32'd1);
        drain(1'b0);

        // Held in_valid: one IDLE cycle between back-to-back requests
        aInValid = 1'b1;
        aSel     = 3'd7;
        aMode    = 2'b00;
        pushExpected(3'd7, 2'b00);
        pushExpected(3'd7, 2'b00);
        tick();
        checkOutput("b2b first out_valid", 32'(aOutValid), 32'd1);
        checkOutput("b2b first in_ready", 32'(aInReady), 32'd0);
        tick();
        checkOutput("b2b gap in_ready", 32'(aInReady), 32'd1);
        checkOutput("b2b gap out_valid", 32'(aOutValid), 32'd0);
        tick();
        aInValid = 1'b0;
        checkOutput("b2b second out_valid", 32'(aOutValid), 32'd1);
        drain(1'b0);

        // Active-low, N=4 instance
        bInValid = 1'b1;
        bSel     = 4'd9;
        bMode    = 2'b00;
        tick();
        bInValid = 1'b0;
        checkOutput("active-low decode d", 32'(bD), 32'hFDFF);
        checkOutput("active-low decode last", 32'(bLast), 32'd1);
        checkOutput("active-low decode out_valid", 32'(bOutValid), 32'd1);
        tick();
        checkOutput("active-low idle out_valid", 32'(bOutValid), 32'd0);
        bInValid = 1'b1;
        bMode    = 2'b11;
        tick();
        bInValid = 1'b0;
        checkOutput("active-low clear d", 32'(bD), 32'hFFFF);
        checkOutput("active-low clear out_valid", 32'(bOutValid), 32'd1);
        tick();

        checkOutput("scoreboard empty", 32'(sbQueue.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
